// File: rtl/bcd_tick_pkg.sv
// Shared types and seven-segment constants for the BCD tick counter.
// Segment byte layout is {dp,g,f,e,d,c,b,a}, active low, dp always off.
package bcd_tick_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segment pattern for one BCD digit; anything else blanks.
    function automatic logic [7:0] seg_decode(input bcd_digit_t d);
        logic [7:0] pattern;
        case (d)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain. A digit moves only when the chain
// steps and the lower digits carry (up) or borrow (down) into it.
module bcd_digit
    import bcd_tick_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    input  logic       down,
    input  logic       carry_in,
    output bcd_digit_t digit,
    output logic       carry_out
);

    bcd_digit_t digit_reg;
    bcd_digit_t digit_next;
    logic       at_limit;

    // A digit at its rollover value passes the carry/borrow upward.
    always_comb begin
        at_limit  = down ? (digit_reg == 4'd0) : (digit_reg >= 4'd9);
        carry_out = carry_in & at_limit;
    end

    // Next value; out-of-range codes fold back into 0..9.
    always_comb begin
        digit_next = digit_reg;
        if (step && carry_in) begin
            if (down) begin
                if (digit_reg == 4'd0 || digit_reg > 4'd9)
                    digit_next = 4'd9;
                else
                    digit_next = digit_reg - 4'd1;
            end else begin
                if (digit_reg >= 4'd9)
                    digit_next = 4'd0;
                else
                    digit_next = digit_reg + 4'd1;
            end
        end
    end

    // Digit register with reset and clear taking priority over stepping.
    always_ff @(posedge clock) begin
        if (reset || clear)
            digit_reg <= 4'd0;
        else
            digit_reg <= digit_next;
    end

    assign digit = digit_reg;

endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled up/down BCD counter with tick, wrap and toggling led outputs.
// Define BCD_TICK_SEG_EN to drive seg from a per-digit seven-segment decode;
// otherwise seg is tied to all ones (all segments off).
module bcd_tick_counter
    import bcd_tick_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int DIV_SLOW = 2500000,
    parameter int DIV_FAST = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  fast,
    input  logic                  down,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  wrap,
    output logic                  led,
    output logic [8*DIGITS-1:0]   seg
);

    localparam int PW = $clog2(DIV_SLOW);
    localparam logic [PW-1:0] LAST_SLOW = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0] LAST_FAST = PW'(DIV_FAST - 1);

    logic [PW-1:0] p_reg;
    logic [PW-1:0] p_next;
    logic [PW-1:0] p_last;
    logic          step;
    logic          tick_reg;
    logic          wrap_reg;
    logic          led_reg;
    logic [DIGITS:0] carry;
    bcd_digit_t    digit_val [DIGITS];

    // Step when the prescaler has reached (or, after a slow-to-fast switch,
    // passed) the last count of the active divisor.
    always_comb begin
        p_last = fast ? LAST_FAST : LAST_SLOW;
        step   = run & (p_reg >= p_last);
        p_next = p_reg;
        if (run)
            p_next = step ? '0 : p_reg + PW'(1);
    end

    // Prescaler and pulse/led registers; reset and clear win over a step.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            p_reg    <= '0;
            tick_reg <= 1'b0;
            wrap_reg <= 1'b0;
            led_reg  <= 1'b0;
        end else begin
            p_reg    <= p_next;
            tick_reg <= step;
            wrap_reg <= step & carry[DIGITS];
            if (step)
                led_reg <= ~led_reg;
        end
    end

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
            bcd_digit u_digit (
                .clock     (clock),
                .reset     (reset),
                .clear     (clear),
                .step      (step),
                .down      (down),
                .carry_in  (carry[gi]),
                .digit     (digit_val[gi]),
                .carry_out (carry[gi+1])
            );
            assign bcd[4*gi +: 4] = digit_val[gi];
        end
    endgenerate

`ifdef BCD_TICK_SEG_EN
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_seg
            assign seg[8*gi +: 8] = seg_decode(digit_val[gi]);
        end
    endgenerate
`else
    assign seg = {(8*DIGITS){1'b1}};
`endif

    assign tick = tick_reg;
    assign wrap = wrap_reg;
    assign led  = led_reg;

endmodule

// File: doc/bcd_tick_counter.md
BCD_TICK_COUNTER -- requirements
Module: bcd_tick_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits, legal range 1..8.
REQ-002 Parameter DIV_SLOW, default 2500000: clock cycles per tick in slow rate; must be at least 2.
REQ-003 Parameter DIV_FAST, default 1000000: clock cycles per tick in fast rate; 2 <= DIV_FAST <= DIV_SLOW.
REQ-004 clock  in  1  sole clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 run  in  1  1 = prescaler and count advance; 0 = hold all state.
REQ-007 fast  in  1  1 = DIV_FAST rate; 0 = DIV_SLOW rate.
REQ-008 down  in  1  1 = count down; 0 = count up.
REQ-009 clear  in  1  synchronous clear of prescaler, count and led.
REQ-010 bcd  out  4*DIGITS  count digits; digit 0 in [3:0] is least significant.
REQ-011 tick  out  1  one-cycle pulse, asserted in the cycle the new count first appears.
REQ-012 wrap  out  1  one-cycle pulse, coincident with tick, when the count wraps.
REQ-013 led  out  1  toggles on every tick.
REQ-014 seg  out  8*DIGITS  active-low seven-segment pattern per digit (see Configuration).

Function
REQ-015 Prescaler: register p of width $clog2(DIV_SLOW); active divisor D = fast ? DIV_FAST : DIV_SLOW.
REQ-016 With run=1 and p < D-1, p increments by 1 on each clock.
REQ-017 With run=1 and p >= D-1, on that edge: p <= 0, count steps once, tick <= 1.
REQ-018 The p >= D-1 comparison covers a slow-to-fast switch while p exceeds DIV_FAST-1; that case ticks on the next edge.
REQ-019 The tick period is exactly D cycles while fast is stable and run=1.
REQ-020 With run=0, p, count and led hold, and tick=0 and wrap=0.
REQ-021 Up step: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
REQ-022 Up step wrap: all digits at 9 step to all digits at 0, and wrap pulses.
REQ-023 Down step: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
REQ-024 Down step wrap: all digits at 0 step to all digits at 9, and wrap pulses.
REQ-025 Each digit always holds a value from 0 to 9; no non-BCD value is ever produced.
REQ-026 down is sampled only on the step edge; changing it mid-period needs no special handling.
REQ-027 led <= ~led on every step edge.
REQ-028 tick and wrap are registered and are 0 in every cycle without a step.
REQ-029 Priority: reset > clear > step.
REQ-030 clear=1: p <= 0, count <= 0, led <= 0, tick <= 0, wrap <= 0, regardless of run.

Reset
REQ-031 On reset=1 at a clock edge, p, all digits, led, tick and wrap are set to 0.
REQ-032 Reset mid-period discards the partial prescale; the first tick after release comes D cycles after release.
REQ-033 No output depends asynchronously on reset; all outputs are driven from registers or from the combinational decode of registers.

Configuration
REQ-034 Macro BCD_TICK_SEG_EN selects the seg output behaviour.
REQ-035 BCD_TICK_SEG_EN defined: seg is the combinational active-low decode of each digit.
REQ-036 Segment order in each byte is {dp,g,f,e,d,c,b,a}, with dp = 1 (off).
REQ-037 BCD_TICK_SEG_EN undefined: the decoder is not instantiated and seg is tied to all ones.
REQ-038 The seg port exists in both builds.

Structure
REQ-039 Package bcd_tick_pkg holds the BCD digit type (4-bit) and the ten seven-segment pattern constants SEG_0..SEG_9.
REQ-040 Package bcd_tick_pkg also holds SEG_BLANK (8'hFF).
REQ-041 One sub-module, bcd_digit, is instantiated DIGITS times in a chain.
REQ-042 bcd_digit inputs: step, down, carry/borrow in.
REQ-043 bcd_digit outputs: digit value, carry/borrow out.
REQ-044 The seven-segment decode is a package function, not a separate module.

Verification (DIGITS=2, DIV_SLOW=5, DIV_FAST=2)
REQ-045 Reset, then run=1, fast=0, down=0 for 25 cycles -> tick every 5 cycles; bcd 0x00..0x05; led toggles 5 times.
REQ-046 Preload to 0x99 via 495 cycles of stepping, then one more step -> bcd=0x00 with tick=1 and wrap=1 in the same cycle.
REQ-047 From 0x00 with down=1, one step -> bcd=0x99 and wrap=1; a further step -> bcd=0x98.
REQ-048 fast=0 with p=4, switch fast=1 -> tick on the next edge; then tick every 2 cycles.
REQ-049 Assert clear and a step on the same edge -> bcd=0, led=0, tick=0; then assert reset with run=0 -> all outputs 0.
REQ-050 Build with BCD_TICK_SEG_EN at bcd=0x42 -> seg={8'h99,8'hA4}; build without it -> seg=16'hFFFF.
